// File: rtl/soc_system_avmm_pkg.sv
// Shared types and constants for the soc_system Avalon-MM polling master.
package soc_system_avmm_pkg;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned LAT_CNT_W = 3;

   localparam logic [DATA_W-1:0] RSP_ERR_DATA = 32'h0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      LAT  = 2'd2,
      RSP  = 2'd3
   } avmm_state_e;

   // Width of a counter that must reach timeout_cycles without wrapping.
   function automatic int unsigned stall_cnt_w(input int unsigned timeout_cycles);
      int unsigned w;
      w = $clog2(timeout_cycles + 32'd1);
      return (w < 32'd1) ? 32'd1 : w;
   endfunction

endpackage

// File: rtl/soc_system_avmm_poll_master.sv
// Single-outstanding Avalon-MM master for PIO-style slaves: command in,
// one-cycle response out, with waitrequest stall timeout and fixed read latency.
module soc_system_avmm_poll_master
   import soc_system_avmm_pkg::*;
#(
   parameter int unsigned ADDR_W         = 2,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error,
   output logic              busy,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic              avm_waitrequest,
   input  logic [DATA_W-1:0] avm_readdata
);

   localparam int unsigned          CNT_W      = stall_cnt_w(TIMEOUT_CYCLES);
   localparam bit                   TIMEOUT_EN = (TIMEOUT_CYCLES != 32'd0);
   localparam logic [CNT_W-1:0]     STALL_LAST =
      CNT_W'((TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0]     STALL_MAX  = '1;
   localparam logic [LAT_CNT_W-1:0] LAT_LOAD   = LAT_CNT_W'(READ_LATENCY - 32'd1);

   avmm_state_e          state, state_d;
   logic                 wr_q, wr_d;
   logic [CNT_W-1:0]     stall_cnt;
   logic [LAT_CNT_W-1:0] lat_cnt;
   logic                 accept, xfer_done, timeout_hit, lat_done;
   logic                 avm_read_d, avm_write_d, rsp_valid_d, busy_d;

   assign cmd_ready   = (state == IDLE);
   assign accept      = cmd_valid && cmd_ready;
   assign xfer_done   = (state == REQ) && !avm_waitrequest;
   // Abort on the edge at which the stall count would reach the limit.
   assign timeout_hit = TIMEOUT_EN && (state == REQ) && avm_waitrequest
                        && (stall_cnt == STALL_LAST);
   assign lat_done    = (state == LAT) && (lat_cnt == '0);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      case (state)
         IDLE: if (cmd_valid) state_d = REQ;
         REQ: begin
            if (xfer_done)        state_d = wr_q ? RSP : LAT;
            else if (timeout_hit) state_d = RSP;
         end
         LAT:     if (lat_done) state_d = RSP;
         RSP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode, evaluated on the next state so the outputs can be registered
   always_comb begin
      wr_d = wr_q;
      if (accept) wr_d = cmd_write;
      avm_read_d  = (state_d == REQ) && !wr_d;
      avm_write_d = (state_d == REQ) && wr_d;
      rsp_valid_d = (state_d == RSP);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         avm_read  <= 1'b0;
         avm_write <= 1'b0;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         avm_read  <= avm_read_d;
         avm_write <= avm_write_d;
         rsp_valid <= rsp_valid_d;
         busy      <= busy_d;
      end
   end

   // Command capture, stall/latency counters and response data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q          <= 1'b0;
         avm_address   <= '0;
         avm_writedata <= '0;
         stall_cnt     <= '0;
         lat_cnt       <= '0;
         rsp_rdata     <= '0;
         rsp_error     <= 1'b0;
      end else begin
         wr_q <= wr_d;

         if (accept) begin
            avm_address   <= cmd_addr;
            avm_writedata <= cmd_wdata;
            stall_cnt     <= '0;
         end else if ((state == REQ) && avm_waitrequest && (stall_cnt != STALL_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end

         if (xfer_done && !wr_q)                      lat_cnt <= LAT_LOAD;
         else if ((state == LAT) && (lat_cnt != '0))  lat_cnt <= lat_cnt - LAT_CNT_W'(1);

         if (xfer_done && wr_q) begin
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
         end else if (timeout_hit) begin
            rsp_rdata <= RSP_ERR_DATA;
            rsp_error <= 1'b1;
         end else if (lat_done) begin
            rsp_rdata <= avm_readdata;
            rsp_error <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_soc_system_avmm_poll_master.sv
// Bench for soc_system_avmm_poll_master: a PIO-like instance (latency 1) and a
// slow-slave instance (latency 3, timeout 4), each against a behavioural slave.
module tb_soc_system_avmm_poll_master;

   localparam int LAT0 = 1, LAT1 = 3, TMO0 = 255, TMO1 = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  cmd_valid, cmd_write, cmd_ready;
   logic [1:0]  rsp_valid, rsp_error, busy, avm_read, avm_write, avm_waitrequest;
   logic [1:0]  cmd_addr [2];
   logic [1:0]  avm_address [2];
   logic [31:0] cmd_wdata [2];
   logic [31:0] rsp_rdata [2];
   logic [31:0] avm_writedata [2];
   logic [31:0] avm_readdata [2];

   logic [31:0] slv_mem [2][4] = '{'{32'h2021_0A0B, 32'h0, 32'h0, 32'h0},
                                   '{32'h2021_0A0B, 32'h0, 32'h0, 32'h0}};
   logic [31:0] ref_mem [2][4];
   logic [1:0]  stuck;
   int          stall_req [2];
   int          wait_cnt [2] = '{0, 0};
   int          rd_cnt [2]   = '{0, 0};
   logic [31:0] rd_data [2];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   soc_system_avmm_poll_master #(.ADDR_W(2), .READ_LATENCY(LAT0), .TIMEOUT_CYCLES(TMO0)) dut0 (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
      .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]),
      .busy(busy[0]), .avm_address(avm_address[0]), .avm_read(avm_read[0]),
      .avm_write(avm_write[0]), .avm_writedata(avm_writedata[0]),
      .avm_waitrequest(avm_waitrequest[0]), .avm_readdata(avm_readdata[0]));

   soc_system_avmm_poll_master #(.ADDR_W(2), .READ_LATENCY(LAT1), .TIMEOUT_CYCLES(TMO1)) dut1 (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
      .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]),
      .busy(busy[1]), .avm_address(avm_address[1]), .avm_read(avm_read[1]),
      .avm_write(avm_write[1]), .avm_writedata(avm_writedata[1]),
      .avm_waitrequest(avm_waitrequest[1]), .avm_readdata(avm_readdata[1]));

   function automatic int lat_of(input int d);
      return (d == 0) ? LAT0 : LAT1;
   endfunction

   function automatic int tmo_of(input int d);
      return (d == 0) ? TMO0 : TMO1;
   endfunction

   // Slave stalls for stall_req cycles (or forever when stuck) on each request.
   always_comb begin
      for (int d = 0; d < 2; d++)
         avm_waitrequest[d] = stuck[d] || (wait_cnt[d] < stall_req[d]);
   end

   // Readdata is valid only in the cycle ending LATENCY edges after acceptance.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rd_cnt[d] > 0) rd_cnt[d] = rd_cnt[d] - 1;
         if (avm_read[d] && !avm_waitrequest[d]) begin
            rd_cnt[d]  = lat_of(d);
            rd_data[d] = slv_mem[d][avm_address[d]];
         end
         if (avm_write[d] && !avm_waitrequest[d])
            slv_mem[d][avm_address[d]] <= avm_writedata[d];
         avm_readdata[d] <= (rd_cnt[d] == 1) ? rd_data[d] : ~rd_data[d];
         if (avm_read[d] || avm_write[d])
            wait_cnt[d] <= avm_waitrequest[d] ? wait_cnt[d] + 1 : 0;
         else
            wait_cnt[d] <= 0;
      end
   end

   task automatic do_txn(input int d, input bit wr, input logic [1:0] addr,
                         input logic [31:0] wdata, input int s);
      int tmo, exp_lat, exp_bus, lat, rd_n, wr_n, ovl, bad_addr, bad_wd;
      logic [31:0] exp_rd, got_rd;
      logic got_err;
      bit tmo_hit, done;
      tmo     = tmo_of(d);
      tmo_hit = (tmo != 0) && (s >= tmo);
      exp_lat = tmo_hit ? tmo + 1 : (wr ? 2 + s : 2 + lat_of(d) + s);
      exp_bus = tmo_hit ? tmo : s + 1;
      exp_rd  = (tmo_hit || wr) ? 32'h0 : ref_mem[d][addr];
      if (wr && !tmo_hit) ref_mem[d][addr] = wdata;
      rd_n = 0; wr_n = 0; ovl = 0; bad_addr = 0; bad_wd = 0; lat = 0;
      done = 1'b0; got_rd = 32'h0; got_err = 1'b0;

      @(negedge clk);
      stuck[d]     = tmo_hit;
      stall_req[d] = tmo_hit ? 0 : s;
      n_cmp++;
      if (cmd_ready[d] !== 1'b1) begin
         n_err++; $display("FAIL txn_ready_pre dut%0d got %b want 1", d, cmd_ready[d]);
      end
      cmd_valid[d] = 1'b1; cmd_write[d] = wr; cmd_addr[d] = addr; cmd_wdata[d] = wdata;
      @(posedge clk);
      for (int k = 1; k <= 60 && !done; k++) begin
         @(negedge clk);
         if (k == 1) cmd_valid[d] = 1'b0;
         if (avm_read[d])  rd_n++;
         if (avm_write[d]) wr_n++;
         if (avm_read[d] && avm_write[d]) ovl++;
         if ((avm_read[d] || avm_write[d]) && avm_address[d] !== addr) bad_addr++;
         if (avm_write[d] && avm_writedata[d] !== wdata) bad_wd++;
         if (rsp_valid[d]) begin
            done = 1'b1; lat = k; got_rd = rsp_rdata[d]; got_err = rsp_error[d];
         end
      end
      n_cmp++;
      if (!done) begin
         n_err++; $display("FAIL txn_no_response dut%0d wr=%0d addr=%0d: no rsp_valid in 60 cycles", d, wr, addr);
      end else begin
         n_cmp++;
         if (lat !== exp_lat) begin
            n_err++; $display("FAIL txn_latency dut%0d wr=%0d s=%0d got %0d want %0d", d, wr, s, lat, exp_lat);
         end
         n_cmp++;
         if (got_rd !== exp_rd) begin
            n_err++; $display("FAIL txn_rdata dut%0d wr=%0d addr=%0d got %h want %h", d, wr, addr, got_rd, exp_rd);
         end
         n_cmp++;
         if (got_err !== tmo_hit) begin
            n_err++; $display("FAIL txn_error dut%0d s=%0d got %b want %b", d, s, got_err, tmo_hit);
         end
      end
      n_cmp++;
      if (rd_n !== (wr ? 0 : exp_bus) || wr_n !== (wr ? exp_bus : 0)) begin
         n_err++; $display("FAIL txn_bus_cycles dut%0d wr=%0d got rd=%0d wr=%0d want %0d", d, wr, rd_n, wr_n, exp_bus);
      end
      n_cmp++;
      if (ovl !== 0 || bad_addr !== 0 || bad_wd !== 0) begin
         n_err++; $display("FAIL txn_bus_stable dut%0d got ovl=%0d addr=%0d wdata=%0d want 0", d, ovl, bad_addr, bad_wd);
      end
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid[d], cmd_ready[d], rsp_rdata[d]} !== {1'b0, 1'b1, exp_rd}) begin
         n_err++; $display("FAIL txn_after_rsp dut%0d got v=%b rdy=%b rdata=%h want v=0 rdy=1 rdata=%h",
                           d, rsp_valid[d], cmd_ready[d], rsp_rdata[d], exp_rd);
      end
      stuck[d] = 1'b0; stall_req[d] = 0;
   endtask

   task automatic test_reset();
      #1 reset_n = 1'b0;
      #2;
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if ({cmd_ready[d], rsp_valid[d], busy[d], avm_read[d], avm_write[d], rsp_error[d]} !== 6'b100000) begin
            n_err++; $display("FAIL reset_ctrl dut%0d got %b want 100000", d,
                              {cmd_ready[d], rsp_valid[d], busy[d], avm_read[d], avm_write[d], rsp_error[d]});
         end
         n_cmp++;
         if ({rsp_rdata[d], avm_writedata[d], avm_address[d]} !== 66'h0) begin
            n_err++; $display("FAIL reset_data dut%0d got %h want 0", d, {rsp_rdata[d], avm_writedata[d], avm_address[d]});
         end
      end
      cmd_valid = 2'b11;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({cmd_ready, busy} !== 4'b1100) begin
         n_err++; $display("FAIL reset_hold got ready=%b busy=%b want 11/00", cmd_ready, busy);
      end
      cmd_valid = 2'b00;
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_pio_read();
      do_txn(0, 1'b0, 2'd0, 32'h0, 0);
      do_txn(0, 1'b0, 2'd2, 32'h0, 0);
   endtask

   task automatic test_pio_write();
      do_txn(0, 1'b1, 2'd1, 32'hCAFE_F00D, 0);
      do_txn(0, 1'b0, 2'd1, 32'h0, 0);
   endtask

   task automatic test_stall_read();
      do_txn(1, 1'b0, 2'd0, 32'h0, 3);
   endtask

   task automatic test_timeout();
      do_txn(1, 1'b0, 2'd2, 32'h0, 4);
      do_txn(1, 1'b1, 2'd3, 32'h1234_5678, 5);
      do_txn(1, 1'b0, 2'd3, 32'h0, 3);
      do_txn(1, 1'b1, 2'd2, 32'h5A5A_0F0F, 0);
      do_txn(1, 1'b0, 2'd2, 32'h0, 0);
   endtask

   task automatic test_back_to_back();
      bit          cw [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [1:0]  ca [4] = '{2'd0, 2'd2, 2'd2, 2'd3};
      logic [32:0] expq [$];
      logic [32:0] exp_v;
      logic [31:0] wd;
      int i = 0, n_rsp = 0, viol = 0;
      bit prev_rsp = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (avm_read[0] && avm_write[0]) viol++;
         if (prev_rsp && (!cmd_ready[0] || rsp_valid[0])) viol++;
         if (rsp_valid[0]) begin
            n_rsp++;
            n_cmp++;
            if (expq.size() == 0) begin
               n_err++; $display("FAIL b2b_extra_rsp got rsp #%0d want 4 total", n_rsp);
            end else begin
               exp_v = expq.pop_front();
               if ({rsp_error[0], rsp_rdata[0]} !== exp_v) begin
                  n_err++; $display("FAIL b2b_rsp%0d got %h want %h", n_rsp, {rsp_error[0], rsp_rdata[0]}, exp_v);
               end
            end
         end
         prev_rsp = rsp_valid[0];
         if (cmd_ready[0] && i < 4) begin
            wd = $urandom;
            cmd_valid[0] = 1'b1; cmd_write[0] = cw[i]; cmd_addr[0] = ca[i]; cmd_wdata[0] = wd;
            expq.push_back({1'b0, cw[i] ? 32'h0 : ref_mem[0][ca[i]]});
            if (cw[i]) ref_mem[0][ca[i]] = wd;
            i++;
         end else if (i == 4 && !cmd_ready[0]) begin
            cmd_valid[0] = 1'b0;
         end
      end
      cmd_valid[0] = 1'b0;
      n_cmp++;
      if (n_rsp !== 4 || i !== 4) begin
         n_err++; $display("FAIL b2b_count got rsp=%0d issued=%0d want 4/4", n_rsp, i);
      end
      n_cmp++;
      if (viol !== 0) begin
         n_err++; $display("FAIL b2b_protocol got %0d violations want 0", viol);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 48; n++) begin
         int d;
         d = n % 2;
         do_txn(d, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), $urandom,
                int'($urandom_range((d == 0) ? 3 : 5, 0)));
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      for (int pass = 0; pass < 2; pass++) begin
         @(negedge clk);
         stuck[1] = (pass == 1);
         cmd_valid[1] = 1'b1; cmd_write[1] = 1'b0; cmd_addr[1] = 2'd0;
         @(posedge clk);
         @(negedge clk);
         cmd_valid[1] = 1'b0;
         @(negedge clk);
         n_cmp++;
         if ({busy[1], avm_read[1]} !== {1'b1, (pass == 1)}) begin
            n_err++; $display("FAIL rstmid_pre%0d got busy=%b rd=%b want 1/%0d", pass, busy[1], avm_read[1], pass);
         end
         #1 reset_n = 1'b0;
         #1;
         n_cmp++;
         if ({avm_read[1], rsp_valid[1], busy[1], cmd_ready[1]} !== 4'b0001) begin
            n_err++; $display("FAIL rstmid_async%0d got %b want 0001", pass,
                              {avm_read[1], rsp_valid[1], busy[1], cmd_ready[1]});
         end
         @(negedge clk);
         reset_n = 1'b1;
         stuck[1] = 1'b0;
         bad = 0;
         repeat (8) begin
            @(negedge clk);
            if (rsp_valid[1] || busy[1] || !cmd_ready[1]) bad++;
         end
         n_cmp++;
         if (bad !== 0) begin
            n_err++; $display("FAIL rstmid_quiet%0d got %0d bad cycles want 0", pass, bad);
         end
      end
      do_txn(1, 1'b0, 2'd1, 32'h0, 1);
   endtask

   initial begin
      reset_n = 1'b1;
      cmd_valid = 2'b00; cmd_write = 2'b00; stuck = 2'b00;
      for (int d = 0; d < 2; d++) begin
         cmd_addr[d] = 2'd0; cmd_wdata[d] = 32'h0; stall_req[d] = 0;
         ref_mem[d][0] = 32'h2021_0A0B;
         for (int a = 1; a < 4; a++) ref_mem[d][a] = 32'h0;
      end
      test_reset();
      test_pio_read();
      test_pio_write();
      test_stall_read();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/soc_system_avmm_poll_master.md
Name: soc_system_avmm_poll_master

Overview:
- Avalon-MM initiator (master) that drives single-word reads and writes into PIO-style Avalon-MM slaves of the soc_system fabric, such as the version/status PIOs.
- Fabric-side logic issues one command at a time over a valid/ready command port and gets a one-cycle response pulse.
- Handles slave waitrequest stalls, fixed read latency and a waitrequest timeout.
- Sits between FPGA-side control logic and the slave's s1 interface.

Parameters:
- ADDR_W, 2, width of avm_address / cmd_addr (word address).
- READ_LATENCY, 1, fixed slave read latency in clk cycles; legal range 1..7.
- TIMEOUT_CYCLES, 255, max cycles of waitrequest stall before abort; 0 disables timeout.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target word address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_error  out  1  timeout abort flag, qualified by rsp_valid.
- busy  out  1  transaction in flight (state != IDLE).
- avm_address  out  ADDR_W  Avalon address.
- avm_read  out  1  Avalon read.
- avm_write  out  1  Avalon write.
- avm_writedata  out  32  Avalon write data.
- avm_waitrequest  in  1  slave stall; tie 0 for slaves without it.
- avm_readdata  in  32  Avalon read data.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. While reset_n is low, all outputs are 0 except cmd_ready, and state = IDLE.
- cmd_ready is combinational: 1 when state = IDLE, also during reset.
- Reset asserted mid-transaction: any state returns to IDLE immediately, avm_read/avm_write drop asynchronously, and no response is produced.
- FSM states: IDLE, REQ, LAT, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready at edge t0: register write flag, address and wdata, then go to REQ.
- REQ:
  - avm_read = ~wr and avm_write = wr; address and writedata are held stable.
  - The transfer is accepted at the edge where avm_waitrequest = 0.
  - Accepted write: go to RSP with rdata = 0, error = 0.
  - Accepted read: load the latency counter with READ_LATENCY - 1, then go to LAT.
  - Stall counter increments each cycle waitrequest = 1. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, drop read/write, go to RSP with error = 1 and rdata = 0.
- LAT:
  - avm_read = 0.
  - When the counter is 0, sample avm_readdata into rsp_rdata and go to RSP. Otherwise decrement.
  - Net effect: readdata is sampled exactly READ_LATENCY cycles after the acceptance edge.
- RSP: rsp_valid = 1 for exactly one cycle, then go to IDLE. rsp_rdata and rsp_error hold their value until the next response.
- Latency with no stall: command accepted at edge t0, avm_read high in cycle t0+1, rsp_valid high in cycle t0+2+READ_LATENCY (t0+3 for a PIO).
  - A write responds at t0+2.
  - Back-to-back: next cmd_ready is asserted the cycle after rsp_valid.
- Commands presented while busy are not accepted. cmd_valid held through busy is taken on the first IDLE edge.
- avm_read and avm_write are never both 1, and neither is high outside REQ.
- Stall counter: width $clog2(TIMEOUT_CYCLES+1), minimum 1; cleared on entry to REQ; saturates, never wraps.

Decomposition:
- Package soc_system_avmm_pkg holds:
  - state enum (IDLE/REQ/LAT/RSP, 2 bits);
  - localparam RSP_ERR_DATA = 32'h0;
  - helper function for counter width.
- No sub-module is required.
- The stall/timeout counter may be split out as avmm_wait_timer (enable, clear, expired) if a second master reuses it.

Test Plan:
- PIO slave model (READ_LATENCY=1, waitrequest=0, readdata = 32'h2021_0A0B at addr 0, 0 elsewhere); read addr 0 → rsp_valid at t0+3, rsp_rdata = 32'h20210A0B, rsp_error = 0; read addr 2 → rsp_rdata = 0.
- Write addr 1, data 32'hCAFE_F00D → single cycle with avm_write = 1, avm_writedata = 32'hCAFEF00D, avm_address = 1; rsp_valid at t0+2, rsp_rdata = 0.
- waitrequest held high 3 cycles on a read, READ_LATENCY=3 → avm_read high 4 cycles with address stable; data sampled 3 cycles after acceptance; rsp_valid at t0+8.
- TIMEOUT_CYCLES=4, waitrequest stuck at 1 → avm_read drops after 4 stalled cycles, rsp_valid with rsp_error = 1 and rsp_rdata = 0; next command then completes normally.
- cmd_valid held continuously with 4 alternating read/write commands → each accepted only when cmd_ready = 1; no overlap of avm_read/avm_write; exactly 4 rsp_valid pulses in order.
- reset_n pulsed low during LAT → avm_read, rsp_valid and busy are 0 asynchronously; no response appears after release; cmd_ready = 1.
